// File: rtl/rvc_fetch_ctrl.sv
// rvc_fetch_ctrl: halfword-aligned fetch PC, I-cache word address, halfword
// select and stitching of word-straddling 32-bit instructions; one raw
// instruction per cycle with PC and compressed flag (1-cycle latency).
// Compressed handling is built only when RVC_FETCH_EN is defined; otherwise
// every fetched word is issued as one 32-bit instruction.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   icache_req_o          read request (low while in reset)
//   icache_addr_o[29:0]   word address (byte address [31:2])
//   icache_rdata_i[31:0]  returned word, cache byte order (byte 0 in [31:24])
//   icache_stall_i        cache miss, rdata invalid this cycle
//   pipe_stall_i          downstream hold
//   redirect_i            jump/branch/flush
//   redirect_pc_i[31:0]   redirect target byte address
//   instr_o[31:0]         raw instruction (16-bit forms zero-extended)
//   instr_valid_o         instr_o / instr_pc_o / is_compress_o valid
//   is_compress_o         instr_o[15:0] is a 16-bit instruction
//   instr_pc_o[31:0]      byte PC of instr_o
module rvc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        icache_req_o,
   output logic [29:0] icache_addr_o,
   input  logic [31:0] icache_rdata_i,
   input  logic        icache_stall_i,
   input  logic        pipe_stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instr_o,
   output logic        instr_valid_o,
   output logic        is_compress_o,
   output logic [31:0] instr_pc_o
);

   logic [31:1] fpc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] w;
   logic        stall_any;

   // Cache delivers byte 0 in the top byte; swap to little-endian order.
   assign w = {icache_rdata_i[7:0],   icache_rdata_i[15:8],
               icache_rdata_i[23:16], icache_rdata_i[31:24]};

   assign stall_any    = icache_stall_i | pipe_stall_i;
   assign icache_req_o = rst_n;

   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign instr_pc_o    = pc_q;

`ifdef RVC_FETCH_EN

   typedef enum logic {FETCH, SPLIT} state_e;

   state_e      state_q;
   logic [15:0] buf_q;
   logic        cmp_q;
   logic [15:0] h;
   logic        unused_ok;

   assign unused_ok     = redirect_pc_i[0];
   assign h             = fpc_q[1] ? w[31:16] : w[15:0];
   assign is_compress_o = cmp_q;

   // In SPLIT the upper half of the instruction lives in the next word.
   assign icache_addr_o = (state_q == SPLIT) ? fpc_q[31:2] + 30'd1
                                             : fpc_q[31:2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_q   <= RESET_PC[31:1];
         state_q <= FETCH;
         buf_q   <= 16'h0;
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         cmp_q   <= 1'b0;
         pc_q    <= 32'h0;
      end else if (redirect_i) begin
         fpc_q   <= redirect_pc_i[31:1];
         state_q <= FETCH;
         buf_q   <= 16'h0;
         valid_q <= 1'b0;
         cmp_q   <= 1'b0;
      end else if (pipe_stall_i) begin
         fpc_q <= fpc_q;
      end else if (stall_any) begin
         valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (w == 32'h0 && !fpc_q[1]) begin
                  // All-zero aligned word: issued as a 32-bit bubble.
                  instr_q <= 32'h0;
                  valid_q <= 1'b1;
                  cmp_q   <= 1'b0;
                  pc_q    <= {fpc_q, 1'b0};
                  fpc_q   <= fpc_q + 31'd2;
               end else if (h[1:0] != 2'b11) begin
                  instr_q <= {16'h0, h};
                  valid_q <= 1'b1;
                  cmp_q   <= 1'b1;
                  pc_q    <= {fpc_q, 1'b0};
                  fpc_q   <= fpc_q + 31'd1;
               end else if (!fpc_q[1]) begin
                  instr_q <= w;
                  valid_q <= 1'b1;
                  cmp_q   <= 1'b0;
                  pc_q    <= {fpc_q, 1'b0};
                  fpc_q   <= fpc_q + 31'd2;
               end else begin
                  // Lower half parked; upper half arrives next word.
                  buf_q   <= w[31:16];
                  state_q <= SPLIT;
                  valid_q <= 1'b0;
               end
            end
            SPLIT: begin
               instr_q <= {w[15:0], buf_q};
               valid_q <= 1'b1;
               cmp_q   <= 1'b0;
               pc_q    <= {fpc_q, 1'b0};
               fpc_q   <= fpc_q + 31'd2;
               state_q <= FETCH;
            end
            default: state_q <= FETCH;
         endcase
      end
   end

`else

   logic unused_ok;

   assign unused_ok     = ^redirect_pc_i[1:0];
   assign is_compress_o = 1'b0;
   assign icache_addr_o = fpc_q[31:2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fpc_q   <= {RESET_PC[31:2], 1'b0};
         instr_q <= 32'h0;
         valid_q <= 1'b0;
         pc_q    <= 32'h0;
      end else if (redirect_i) begin
         fpc_q   <= {redirect_pc_i[31:2], 1'b0};
         valid_q <= 1'b0;
      end else if (pipe_stall_i) begin
         fpc_q <= fpc_q;
      end else if (stall_any) begin
         valid_q <= 1'b0;
      end else begin
         instr_q <= w;
         valid_q <= 1'b1;
         pc_q    <= {fpc_q, 1'b0};
         fpc_q   <= fpc_q + 31'd2;
      end
   end

`endif

endmodule

// File: doc/rvc_fetch_ctrl.md
# rvc_fetch_ctrl

Fetch-side controller for the compressed-ISA front end. It owns the halfword-aligned fetch PC, drives the word address to the I-cache, and selects which halfword of each returned word starts the next instruction. It stitches 32-bit instructions that straddle a word boundary and issues one raw instruction per cycle, with its PC and a compressed flag, to the downstream decompressor/IF-ID register. It sequences the alignment datapath; it does not decompress.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset; bit 0 must be 0.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- icache_req_o  out  1  read request; 0 while rst_n=0, else 1
- icache_addr_o  out  30  word address (byte address [31:2]); combinational from state
- icache_rdata_i  in  32  returned word; byte 0 in [31:24] (cache byte order), swapped internally to w = {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}
- icache_stall_i  in  1  cache miss; rdata invalid this cycle
- pipe_stall_i  in  1  downstream hold
- redirect_i  in  1  jump/branch/flush
- redirect_pc_i  in  32  redirect target; bit 0 ignored
- instr_o  out  32  raw instruction; compressed forms zero-extended in [15:0]
- instr_valid_o  out  1  instr_o/instr_pc_o/is_compress_o valid
- is_compress_o  out  1  instr_o[15:0] is a 16-bit instruction
- instr_pc_o  out  32  byte PC of instr_o

## Operation
- State: fpc[31:1], fsm {FETCH, SPLIT}, buf[15:0] (lower half of straddling instruction), registered outputs.
- Accept = ~icache_stall_i & ~pipe_stall_i & ~redirect_i.
- icache_addr_o = fpc[31:2] in FETCH; fpc[31:2]+1 in SPLIT (wraps mod 2^30).
- FETCH, off = fpc[1], h = off ? w[31:16] : w[15:0]. On accept:
  - w == 0 and off == 0: emit 32'h0, is_compress=0, fpc += 4 (bubble convention).
  - h[1:0] != 2'b11: emit {16'h0,h}, is_compress=1, fpc += 2.
  - h[1:0] == 2'b11, off == 0: emit w, is_compress=0, fpc += 4.
  - h[1:0] == 2'b11, off == 1: buf = w[31:16], go SPLIT, no emit (instr_valid_o=0 next cycle), fpc unchanged.
- SPLIT on accept: emit {w[15:0], buf}, is_compress=0, instr_pc = fpc, fpc += 4, go FETCH.
- Emit = registered outputs loaded, instr_valid_o=1, instr_pc_o = fpc before update.
- Priority: rst_n=0 > redirect_i > pipe_stall_i > icache_stall_i.
- redirect_i (even when either stall is high): fpc = {redirect_pc_i[31:1]}, fsm = FETCH, buf = 0, instr_valid_o = 0 next cycle, is_compress_o = 0.
- pipe_stall_i (no redirect): all state and outputs hold.
- icache_stall_i only: state holds; instr_valid_o = 0 next cycle (bubble), other outputs hold.
- PC arithmetic is 32-bit modulo 2^32.

## Timing
- Reset values: fpc = RESET_PC, fsm = FETCH, buf = 0, instr_o = 0, instr_valid_o = 0, is_compress_o = 0, instr_pc_o = 0, icache_req_o = 0 (during reset).
- Cache is zero-latency: address presented in cycle n, data sampled in cycle n if icache_stall_i = 0.
- Instruction sampled in cycle n appears on outputs after edge n+1 (1-cycle latency).
- Throughput: 1 instruction/cycle, except straddling 32-bit instruction: 2 cycles, 1 bubble.
- Redirect target's first instruction is valid 1 cycle after the first non-stalled cycle following redirect.
- Reset asserted mid-SPLIT discards buf; first fetch after release is at RESET_PC.

## Configuration
- RVC_FETCH_EN defined: full compressed handling as above.
- Undefined: every word is treated as a 32-bit instruction, fpc += 4, fpc[1] forced 0 (redirect_pc_i[1] ignored), SPLIT and buf not built, is_compress_o tied 0.

## Test plan
- Reset, RESET_PC=0, words 0x00000013-style (post-swap w=0x00A00093) back-to-back -> instr_pc_o 0,4,8, is_compress_o=0, one per cycle starting cycle after first fetch.
- Word w=0x4505_4501 (two c.li) at pc 0 -> emits 0x00004501 @pc0 then 0x00004505 @pc2, both is_compress=1, both with icache_addr_o=0, then addr=1.
- pc 2 halfword 0x0093, next word low half 0x00A0 -> one bubble, then emits 0x00A00093 @pc2, is_compress=0, fpc=6.
- icache_stall_i held 3 cycles mid-SPLIT -> instr_valid_o=0 for 3 cycles, buf preserved, correct stitched instruction after stall drops.
- pipe_stall_i high with redirect_i=1 to 0x102 -> outputs invalid next cycle, icache_addr_o=0x40, first emitted instr_pc_o=0x102 from upper half.
- RVC_FETCH_EN undefined, redirect to 0x102 -> fetch at 0x100, is_compress_o stays 0, pc steps of 4.
